dnn_accuracy_monitor: RTL

Synthesizable, parametrised training-accuracy monitor for the DNN. It sits beside the DNN top, sampling the thresholded output `a_out_alln`, the ideal output `y_out` and the raw output activations once per training case. It scores each case by exact-match or argmax and maintains a sliding-window correct count, a running total and per-epoch statistics in hardware, so FPGA runs report accuracy without a simulator.

---
 rtl/dnn_accuracy_monitor.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dnn_accuracy_monitor.sv
// Training-accuracy monitor for the DNN: scores each case by exact match or argmax and
// keeps a sliding-window correct count, running totals and per-epoch statistics.
module dnn_accuracy_monitor #(
    parameter int width           = 16,
    parameter int n_out           = 16,
    parameter int n_valid         = 10,
    parameter int window          = 1000,
    parameter int cases_per_epoch = 10000,
    parameter int mode            = 0,
    parameter int cnt_w           = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   eval_valid,
    input  logic                                   clear_stats,
    input  logic [n_out-1:0]                       a_out,
    input  logic [n_out-1:0]                       y_out,
    input  logic [width*n_out-1:0]                 act,
    output logic                                   correct,
    output logic                                   correct_valid,
    output logic [$clog2(window+1)-1:0]            recent,
    output logic                                   window_full,
    output logic [cnt_w-1:0]                       case_count,
    output logic [cnt_w-1:0]                       total_correct,
    output logic [15:0]                            epoch,
    output logic                                   epoch_done,
    output logic [$clog2(cases_per_epoch+1)-1:0]   epoch_correct
);

    localparam int RECENT_W = $clog2(window + 1);
    localparam int PTR_W    = $clog2(window);
    localparam int EPC_W    = $clog2(cases_per_epoch + 1);
    localparam int EPI_W    = $clog2(cases_per_epoch);
    localparam int IDX_W    = (n_out > 1) ? $clog2(n_out) : 1;
    localparam int LEAVES   = 1 << $clog2(n_valid);
    localparam int NODES    = 2 * LEAVES - 1;

    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(window - 1);
    localparam logic [EPI_W-1:0] EP_IDX_END = EPI_W'(cases_per_epoch - 1);

    // ------------------------------------------------------------------
    // Argmax tree: leaves padded to a power of two, padding leaves never win
    // ------------------------------------------------------------------
    logic signed [width-1:0] leaf_val [LEAVES];
    logic [IDX_W-1:0]        leaf_idx [LEAVES];
    logic                    leaf_ok  [LEAVES];

    genvar gi;
    generate
        for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < n_valid) begin : g_used
                assign leaf_val[gi] = act[width*gi +: width];
                assign leaf_ok[gi]  = 1'b1;
            end else begin : g_pad
                assign leaf_val[gi] = '0;
                assign leaf_ok[gi]  = 1'b0;
            end
            assign leaf_idx[gi] = IDX_W'(gi);
        end
    endgenerate

    logic signed [width-1:0] node_val [NODES];
    logic [IDX_W-1:0]        node_idx [NODES];
    logic                    node_ok  [NODES];

    // Heap layout: left child always covers lower indices, so ties keep the left one
    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            node_val[i] = '0;
            node_idx[i] = '0;
            node_ok[i]  = 1'b0;
        end
        for (int i = 0; i < LEAVES; i++) begin
            node_val[LEAVES-1+i] = leaf_val[i];
            node_idx[LEAVES-1+i] = leaf_idx[i];
            node_ok[LEAVES-1+i]  = leaf_ok[i];
        end
        for (int k = LEAVES - 2; k >= 0; k--) begin
            if (node_ok[2*k+1] && (!node_ok[2*k+2] || (node_val[2*k+1] >= node_val[2*k+2]))) begin
                node_val[k] = node_val[2*k+1];
                node_idx[k] = node_idx[2*k+1];
            end else begin
                node_val[k] = node_val[2*k+2];
                node_idx[k] = node_idx[2*k+2];
            end
            node_ok[k] = node_ok[2*k+1] | node_ok[2*k+2];
        end
    end

    logic [IDX_W-1:0] ideal_idx;
    logic             ideal_hit;

    always_comb begin
        ideal_idx = '0;
        ideal_hit = 1'b0;
        for (int i = n_valid - 1; i >= 0; i--) begin
            if (y_out[i]) begin
                ideal_idx = IDX_W'(i);
                ideal_hit = 1'b1;
            end
        end
    end

    logic score_exact;
    logic score_argmax;
    logic score;

    assign score_exact  = (a_out[n_valid-1:0] == y_out[n_valid-1:0]);
    assign score_argmax = ideal_hit && node_ok[0] && (node_idx[0] == ideal_idx);
    assign score        = (mode == 1) ? score_argmax : score_exact;

    // Neurons beyond n_valid are deliberately ignored
    logic unused_inputs;
    assign unused_inputs = ^{a_out, y_out, act};

    // ------------------------------------------------------------------
    // Statistics registers
    // ------------------------------------------------------------------
    logic [window-1:0]   hist_reg;
    logic [PTR_W-1:0]    ptr_reg;
    logic [RECENT_W-1:0] recent_reg;
    logic                window_full_reg;
    logic                correct_reg;
    logic                correct_valid_reg;
    logic [cnt_w-1:0]    case_count_reg;
    logic [cnt_w-1:0]    total_correct_reg;
    logic [15:0]         epoch_reg;
    logic                epoch_done_reg;
    logic [EPC_W-1:0]    epoch_correct_reg;
    logic [EPI_W-1:0]    ep_idx_reg;
    logic [EPC_W-1:0]    ep_cnt_reg;

    // The history is a flop vector so a clear takes one cycle and there is no busy period
    always_ff @(posedge clk) begin
        if (!reset || clear_stats) begin
            hist_reg          <= '0;
            ptr_reg           <= '0;
            recent_reg        <= '0;
            window_full_reg   <= 1'b0;
            correct_reg       <= 1'b0;
            correct_valid_reg <= 1'b0;
            case_count_reg    <= '0;
            total_correct_reg <= '0;
            epoch_reg         <= '0;
            epoch_done_reg    <= 1'b0;
            epoch_correct_reg <= '0;
            ep_idx_reg        <= '0;
            ep_cnt_reg        <= '0;
        end else begin
            correct_valid_reg <= 1'b0;
            epoch_done_reg    <= 1'b0;
            if (eval_valid) begin
                correct_reg       <= score;
                correct_valid_reg <= 1'b1;

                recent_reg        <= recent_reg + RECENT_W'(score) - RECENT_W'(hist_reg[ptr_reg]);
                hist_reg[ptr_reg] <= score;
                if (ptr_reg == PTR_LAST) begin
                    ptr_reg         <= '0;
                    window_full_reg <= 1'b1;
                end else begin
                    ptr_reg <= ptr_reg + PTR_W'(1);
                end

                case_count_reg <= case_count_reg + cnt_w'(1);
                if (score && (total_correct_reg != {cnt_w{1'b1}})) begin
                    total_correct_reg <= total_correct_reg + cnt_w'(1);
                end

                if (ep_idx_reg == EP_IDX_END) begin
                    epoch_correct_reg <= ep_cnt_reg + EPC_W'(score);
                    epoch_reg         <= epoch_reg + 16'd1;
                    epoch_done_reg    <= 1'b1;
                    ep_idx_reg        <= '0;
                    ep_cnt_reg        <= '0;
                end else begin
                    ep_idx_reg <= ep_idx_reg + EPI_W'(1);
                    ep_cnt_reg <= ep_cnt_reg + EPC_W'(score);
                end
            end
        end
    end

    assign correct       = correct_reg;
    assign correct_valid = correct_valid_reg;
    assign recent        = recent_reg;
    assign window_full   = window_full_reg;
    assign case_count    = case_count_reg;
    assign total_correct = total_correct_reg;
    assign epoch         = epoch_reg;
    assign epoch_done    = epoch_done_reg;
    assign epoch_correct = epoch_correct_reg;

endmodule
